// File: rtl/svm_seq_pkg.sv
// -----------------------------------------------------------------------------
// svm_seq_pkg
//   Shared definitions for the SVM sample sequencer:
//     - state_t       : sequencer FSM states
//     - DEF_*         : default geometry of the SVM core interface
//     - sample_width(): packed sample width from feature count and feature width
// -----------------------------------------------------------------------------
package svm_seq_pkg;

  localparam int DEF_N_FEATURES  = 33;
  localparam int DEF_INPUT_WIDTH = 4;
  localparam int DEF_CLASS_BITS  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    RESULT
  } state_t;

  function automatic int sample_width(input int n_features, input int input_width);
    return n_features * input_width;
  endfunction

endpackage

// File: rtl/svm_sat_counter.sv
// -----------------------------------------------------------------------------
// svm_sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     clr      : synchronous clear (wins over inc)
//     inc      : count one event; holds at all-ones
//     q        : current count
// -----------------------------------------------------------------------------
module svm_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/svm_sample_sequencer.sv
// -----------------------------------------------------------------------------
// svm_sample_sequencer
//   Synthesizable initiator for the sequential SVM core. Takes labelled
//   samples from a valid/ready stream, presents each one to the core after a
//   one-cycle core reset, waits for the core's ready rising edge (bounded by
//   TIMEOUT cycles), and emits a result record compared against the label.
//   Running total/correct counters support on-chip accuracy measurement.
//
//   Ports:
//     clk, rst             : clock, asynchronous active-high reset
//     s_valid/s_ready      : sample stream handshake
//     s_sample, s_label    : packed feature vector and its expected class
//     core_in, core_rst_n  : sample and active-low reset driven to the core
//     core_ready,core_class: core done flag and predicted class
//     r_valid/r_accept     : result handshake
//     r_class, r_label     : captured prediction and the sample's label
//     r_match, r_timeout   : prediction correct / core did not finish in time
//     clear_stats          : synchronous clear of the statistics counters
//     total_cnt,correct_cnt: saturating result counters
// -----------------------------------------------------------------------------
module svm_sample_sequencer
  import svm_seq_pkg::*;
#(
  parameter  int N_FEATURES  = DEF_N_FEATURES,
  parameter  int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter  int CLASS_BITS  = DEF_CLASS_BITS,
  parameter  int CNT_WIDTH   = 16,
  parameter  int TIMEOUT     = 64,
  localparam int SW          = sample_width(N_FEATURES, INPUT_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [SW-1:0]         s_sample,
  input  logic [CLASS_BITS-1:0] s_label,
  output logic [SW-1:0]         core_in,
  output logic                  core_rst_n,
  input  logic                  core_ready,
  input  logic [CLASS_BITS-1:0] core_class,
  output logic                  r_valid,
  input  logic                  r_accept,
  output logic [CLASS_BITS-1:0] r_class,
  output logic [CLASS_BITS-1:0] r_label,
  output logic                  r_match,
  output logic                  r_timeout,
  input  logic                  clear_stats,
  output logic [CNT_WIDTH-1:0]  total_cnt,
  output logic [CNT_WIDTH-1:0]  correct_cnt
);

  localparam int            TW      = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t                  state;
  logic                    ready_q;
  logic [TW-1:0]           to_cnt;
  logic [CLASS_BITS-1:0]   label_q;
  logic                    rise;
  logic                    result_taken;

  // ready_q is cleared in LOAD, so a ready already high on the first RUN
  // cycle is seen as a rising edge.
  assign rise = core_ready & ~ready_q;

  // Stream ready drops immediately with rst, not one edge later.
  assign s_ready    = (state == IDLE) & ~rst;
  assign core_rst_n = (state == RUN) | (state == CAPTURE);
  assign r_valid    = (state == RESULT);
  assign r_label    = label_q;
  assign r_match    = (r_class == label_q) & ~r_timeout;

  assign result_taken = r_valid & r_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      core_in   <= '0;
      label_q   <= '0;
      ready_q   <= 1'b0;
      to_cnt    <= '0;
      r_class   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // s_ready is simply "in IDLE" here, since rst is low on this path.
          if (s_valid) begin
            core_in <= s_sample;
            label_q <= s_label;
            state   <= LOAD;
          end
        end
        LOAD: begin
          to_cnt  <= '0;
          ready_q <= 1'b0;
          state   <= RUN;
        end
        RUN: begin
          ready_q <= core_ready;
          to_cnt  <= to_cnt + 1'b1;
          // A rise in the last allowed cycle still counts as completion.
          if (rise) begin
            state <= CAPTURE;
          end else if (to_cnt == TO_LAST) begin
            r_class   <= '0;
            r_timeout <= 1'b1;
            state     <= RESULT;
          end
        end
        CAPTURE: begin
          r_class   <= core_class;
          r_timeout <= 1'b0;
          state     <= RESULT;
        end
        RESULT: begin
          if (r_accept) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear_stats overrides a coincident handshake; that result is still
  // consumed by the FSM but not counted.
  svm_sat_counter #(.WIDTH(CNT_WIDTH)) u_total_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_stats),
    .inc (result_taken),
    .q   (total_cnt)
  );

  svm_sat_counter #(.WIDTH(CNT_WIDTH)) u_correct_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_stats),
    .inc (result_taken & r_match),
    .q   (correct_cnt)
  );

endmodule

// File: tb/tb_svm_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_svm_sample_sequencer
//   Directed sequence with randomized samples, delays and classes. A stub core
//   raises core_ready a programmable number of cycles after core_rst_n rises.
//   Expected latency and result fields come from a transaction-level model;
//   expected counters come from plain saturating arithmetic.
// -----------------------------------------------------------------------------
module tb_svm_sample_sequencer;

  localparam int SW  = 132;
  localparam int CB  = 3;
  localparam int CW  = 4;
  localparam int TO  = 64;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_sample = '0;
  logic [CB-1:0] s_label = '0;
  logic [SW-1:0] core_in;
  logic          core_rst_n;
  logic          core_ready;
  logic [CB-1:0] core_class;
  logic          r_valid;
  logic          r_accept = 1'b0;
  logic [CB-1:0] r_class;
  logic [CB-1:0] r_label;
  logic          r_match;
  logic          r_timeout;
  logic          clear_stats = 1'b0;
  logic [CW-1:0] total_cnt;
  logic [CW-1:0] correct_cnt;

  int checks = 0;
  int passed = 0;
  int exp_total = 0;
  int exp_correct = 0;

  // Stub core: ready goes high stub_delay cycles after core_rst_n rises.
  int            stub_delay = -1;
  logic [CB-1:0] stub_class = '0;
  int            stub_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!core_rst_n) stub_cnt <= 0;
    else             stub_cnt <= stub_cnt + 1;
  end

  assign core_ready = core_rst_n && (stub_delay >= 0) && (stub_cnt >= stub_delay);
  assign core_class = stub_class;

  svm_sample_sequencer #(
    .N_FEATURES  (33),
    .INPUT_WIDTH (4),
    .CLASS_BITS  (CB),
    .CNT_WIDTH   (CW),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_sample    (s_sample),
    .s_label     (s_label),
    .core_in     (core_in),
    .core_rst_n  (core_rst_n),
    .core_ready  (core_ready),
    .core_class  (core_class),
    .r_valid     (r_valid),
    .r_accept    (r_accept),
    .r_class     (r_class),
    .r_label     (r_label),
    .r_match     (r_match),
    .r_timeout   (r_timeout),
    .clear_stats (clear_stats),
    .total_cnt   (total_cnt),
    .correct_cnt (correct_cnt)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] rand_sample();
    logic [159:0] v;
    for (int i = 0; i < 5; i++) v[i*32 +: 32] = $urandom;
    return v[SW-1:0];
  endfunction

  function automatic int sat_inc(input int v);
    return (v < MAX) ? v + 1 : v;
  endfunction

  // One full transaction: offer a sample, follow it through the core, check
  // the result after 'hold' stall cycles, then accept (optionally with clear).
  task automatic txn(input logic [CB-1:0] label, input logic [CB-1:0] cls,
                     input int delay, input int hold, input bit clr);
    logic [SW-1:0] smp;
    logic [CB-1:0] exp_cls;
    bit            exp_to;
    bit            exp_match;
    int            exp_lat;
    int            n;

    smp        = rand_sample();
    stub_delay = delay;
    stub_class = cls;

    // Model: the core finishes if its ready arrives within TO RUN cycles.
    exp_to    = (delay < 0) || (delay > TO - 1);
    exp_lat   = exp_to ? TO + 2 : delay + 4;
    exp_cls   = exp_to ? '0 : cls;
    exp_match = !exp_to && (cls == label);

    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_idle", s_ready, 1);
    s_valid  = 1'b1;
    s_sample = smp;
    s_label  = label;
    @(negedge clk);
    s_valid  = 1'b0;
    s_sample = rand_sample();
    s_label  = ~label;
    check("load_core_rst_n", core_rst_n, 0);
    check("load_s_ready", s_ready, 0);
    check("core_in", core_in, smp);
    @(negedge clk);
    check("run_core_rst_n", core_rst_n, 1);
    n = 2;
    while (!r_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat);
    check("r_class", r_class, exp_cls);
    check("r_label", r_label, label);
    check("r_match", r_match, exp_match);
    check("r_timeout", r_timeout, exp_to);

    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold_r_valid", r_valid, 1);
      check("hold_s_ready", s_ready, 0);
      check("hold_r_class", r_class, exp_cls);
      check("hold_r_label", r_label, label);
      check("hold_core_in", core_in, smp);
    end

    r_accept    = 1'b1;
    clear_stats = clr;
    @(negedge clk);
    r_accept    = 1'b0;
    clear_stats = 1'b0;
    if (clr) begin
      exp_total   = 0;
      exp_correct = 0;
    end else begin
      exp_total = sat_inc(exp_total);
      if (exp_match) exp_correct = sat_inc(exp_correct);
    end
    check("post_r_valid", r_valid, 0);
    check("post_s_ready", s_ready, 1);
    check("total_cnt", total_cnt, exp_total);
    check("correct_cnt", correct_cnt, exp_correct);
  endtask

  initial begin
    logic [CB-1:0] lbl;

    // Reset state.
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_total", total_cnt, 0);
    check("rst_correct", correct_cnt, 0);
    check("rst_core_in", core_in, 0);
    rst = 1'b0;
    @(negedge clk);

    // Matching result, core ready 10 cycles after release.
    txn(3'd3, 3'd3, 10, 0, 1'b0);
    // Mismatch.
    txn(3'd2, 3'd5, 10, 0, 1'b0);
    // Core never finishes.
    txn(3'd1, 3'd1, -1, 0, 1'b0);
    // Result stalled 20 cycles.
    txn(3'd6, 3'd6, int'($urandom_range(1, 20)), 20, 1'b0);
    // Ready already high on the first RUN cycle.
    txn(3'd4, 3'd4, 0, 0, 1'b0);
    // Rise in the last allowed cycle beats the timeout.
    txn(3'd7, 3'd7, TO - 1, 0, 1'b0);
    // First ready one cycle too late.
    txn(3'd0, 3'd0, TO, 0, 1'b0);

    // Random mix.
    for (int i = 0; i < 6; i++) begin
      lbl = CB'($urandom);
      txn(lbl, ($urandom_range(0, 1) != 0) ? lbl : CB'($urandom),
          int'($urandom_range(0, 30)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Saturation: clear, then 20 matching samples.
    txn(3'd5, 3'd5, 3, 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      lbl = CB'($urandom);
      txn(lbl, lbl, int'($urandom_range(0, 12)), 0, 1'b0);
    end
    check("sat_total", total_cnt, MAX);
    check("sat_correct", correct_cnt, MAX);

    // Clear coincident with a handshake, then one counted result.
    txn(3'd2, 3'd2, 5, 0, 1'b1);
    txn(3'd2, 3'd2, 5, 0, 1'b0);
    check("after_clear_total", total_cnt, 1);
    check("after_clear_correct", correct_cnt, 1);

    // Reset during RUN: nothing is emitted and counters clear.
    stub_delay = -1;
    s_valid    = 1'b1;
    s_sample   = rand_sample();
    s_label    = 3'd1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_core_rst_n", core_rst_n, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_core_rst_n", core_rst_n, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_r_valid", r_valid, 0);
    check("mid_rst_total", total_cnt, 0);
    check("mid_rst_correct", correct_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_s_ready", s_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rel_r_valid", r_valid, 0);
      check("rel_core_rst_n", core_rst_n, 0);
    end
    exp_total   = 0;
    exp_correct = 0;
    txn(3'd3, 3'd3, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/svm_sample_sequencer.md
Name: svm_sample_sequencer

Overview:
- Hardware initiator for the sequential SVM core (`top`). It replaces the simulation-only driver with synthesizable logic.
- Accepts labelled samples on a valid/ready stream and presents each one to the core, holding the core in reset for one cycle beforehand.
- Waits for the core's ready rising edge, captures the predicted class and compares it with the label.
- Emits a result record and keeps running total/correct counters for on-chip accuracy measurement.

Parameters:
N_FEATURES, 33, number of input features
INPUT_WIDTH, 4, bits per feature; sample width SW = N_FEATURES*INPUT_WIDTH (132)
CLASS_BITS, 3, width of class index / label
CNT_WIDTH, 16, width of statistics counters (saturating)
TIMEOUT, 64, max cycles in RUN before the sample is aborted (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  sample stream valid
s_ready  out  1  sample stream ready
s_sample  in  SW  packed feature vector
s_label  in  CLASS_BITS  expected class
core_in  out  SW  sample driven to core `in`
core_rst_n  out  1  core reset, active-low
core_ready  in  1  core done flag
core_class  in  CLASS_BITS  core w_class output
r_valid  out  1  result valid
r_accept  in  1  result consumer ready
r_class  out  CLASS_BITS  captured prediction
r_label  out  CLASS_BITS  label of that sample
r_match  out  1  r_class == r_label and not timeout
r_timeout  out  1  core did not finish within TIMEOUT
clear_stats  in  1  synchronous clear of counters
total_cnt  out  CNT_WIDTH  results delivered
correct_cnt  out  CNT_WIDTH  matching results delivered

Behaviour:
- Reset (async, rst=1): state IDLE; all registers 0; core_rst_n=0; s_ready=0; r_valid=0; counters 0. Everything is forced back to these values if rst rises mid-operation; no partial result is emitted.
- s_ready = (state==IDLE) & ~rst. core_rst_n = 1 only in RUN and CAPTURE.
- FSM states and transitions:
  - IDLE: on s_valid&s_ready, latch s_sample into core_in and s_label into the label register; go to LOAD.
  - LOAD (1 cycle): core_rst_n=0, core_in stable; clear timeout counter and ready_q; go to RUN.
  - RUN: core_rst_n=1; ready_q <= core_ready; timeout counter increments each cycle.
    - rise = core_ready & ~ready_q -> CAPTURE.
    - Counter reaching TIMEOUT-1 without rise -> RESULT with r_timeout=1, r_class=0.
    - rise and timeout in the same cycle: rise wins.
  - CAPTURE (1 cycle): register core_class into r_class; r_timeout=0; go to RESULT.
  - RESULT: r_valid=1; r_class/r_label/r_match/r_timeout held stable. On r_accept, go to IDLE with r_valid=0 next cycle.
- core_in holds its value through IDLE until the next accept; the core sees it under reset.
- Latency: accept at cycle 0 -> LOAD at 1 -> RUN from 2.
  - First observed core_ready high in RUN at cycle t -> CAPTURE at t+1 -> r_valid at t+2.
  - Minimum accept-to-next-accept is 5 cycles.
- A core_ready already high on the first RUN cycle counts as a rise, because ready_q was cleared in LOAD.
- Counters:
  - On r_valid&r_accept: total_cnt+1; correct_cnt+1 if r_match.
  - Both saturate at 2^CNT_WIDTH-1.
  - clear_stats zeros both. It has priority over a coincident handshake; that handshake is not counted but the result is still consumed.
- r_match is computed combinationally from the registered r_class, r_label and r_timeout.

Decomposition:
- Package svm_seq_pkg:
  - state enum {IDLE, LOAD, RUN, CAPTURE, RESULT}
  - default CLASS_BITS, INPUT_WIDTH and N_FEATURES constants
  - sample-width localparam helper
- One sub-module: svm_sat_counter. Parameterized width; inputs inc, clr (clr priority); saturating output. Instantiated twice, for total and correct.

Test Plan:
- Reset then stream, label 3, stub core asserts core_ready 10 cycles after core_rst_n rises with class 3 -> core_rst_n low exactly 1 cycle; r_valid at accept+14; r_class=3, r_match=1; total=1, correct=1.
- Stub core returns class 5 for label 2 -> r_match=0; total increments, correct unchanged.
- Core never asserts ready, TIMEOUT=64 -> r_valid after 64 RUN cycles; r_timeout=1, r_class=0, r_match=0.
- r_accept held low 20 cycles in RESULT -> outputs stable, s_ready=0, no new accept; accept releases and s_ready=1 next cycle.
- CNT_WIDTH=4, 20 matching samples -> total=correct=15 (saturated). clear_stats coincident with a handshake -> both 0, then next result gives 1.
- rst pulsed during RUN -> core_rst_n=0, s_ready=1 after release, no r_valid, counters 0.
